// File: rtl/conv1x1_layer_scheduler_if.sv
// Layer descriptor handshake bus from the layer-config bank to the 1x1 conv scheduler.
interface conv1x1_layer_scheduler_if #(
  parameter int unsigned PIX_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PIX_W-1:0] cfg_num_pixel;
  logic [10:0]      cfg_weight_c;
  logic [10:0]      cfg_num_filter;
  logic [31:0]      cfg_ofm_base;

  modport master (
    output cfg_valid, cfg_num_pixel, cfg_weight_c, cfg_num_filter, cfg_ofm_base,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_num_pixel, cfg_weight_c, cfg_num_filter, cfg_ofm_base,
    output cfg_ready
  );
endinterface

// File: rtl/conv1x1_layer_scheduler.sv
// Layer sequencer for the 1x1 conv datapath: validates a descriptor, runs the
// controller, turns each all-lanes finish into one OFM group write, ends with done.
module conv1x1_layer_scheduler #(
  parameter int unsigned PE_LANES = 4,
  parameter int unsigned PIX_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  conv1x1_layer_scheduler_if.slave cfg,
  input  logic                   abort,
  output logic                   ctrl_cal_start,
  output logic [10:0]            ctrl_weight_c,
  output logic [10:0]            ctrl_num_filter,
  input  logic [PE_LANES-1:0]    ctrl_pe_finish,
  output logic                   ofm_wr_en,
  output logic [31:0]            ofm_wr_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   err_cfg
);

  localparam int unsigned CW = 11;
  localparam int unsigned AW = 32;
  localparam int unsigned LB = $clog2(PE_LANES);

  typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

  state_t           state;
  logic [PIX_W-1:0] num_pixel_q;
  logic [PIX_W-1:0] pix_cnt;
  logic [CW-1:0]    grp_cnt;
  logic [AW-1:0]    ofm_base_q;
  logic             fin_q;

  logic             all_ones_c;
  logic             fin_evt_c;
  logic [CW-1:0]    num_grp_c;
  logic             last_grp_c;
  logic             last_pix_c;
  logic             illegal_c;
  logic [AW-1:0]    wr_addr_c;

  // Event detection, descriptor legality and group address
  always_comb begin
    all_ones_c = &ctrl_pe_finish;
    fin_evt_c  = all_ones_c & ~fin_q;
    num_grp_c  = ctrl_num_filter >> LB;
    last_grp_c = (grp_cnt == num_grp_c - CW'(1));
    last_pix_c = (pix_cnt == num_pixel_q - PIX_W'(1));
    illegal_c  = (ctrl_weight_c == '0)
               | ((ctrl_weight_c & CW'(PE_LANES - 1)) != '0)
               | (ctrl_num_filter == '0)
               | ((ctrl_num_filter & CW'(PE_LANES - 1)) != '0)
               | (num_pixel_q == '0);
    wr_addr_c  = ofm_base_q
               + AW'(pix_cnt) * AW'(ctrl_num_filter)
               + AW'(grp_cnt) * AW'(PE_LANES);
  end

  // Sequencer with registered outputs; abort overrides every non-IDLE transition
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      num_pixel_q     <= '0;
      pix_cnt         <= '0;
      grp_cnt         <= '0;
      ofm_base_q      <= '0;
      fin_q           <= 1'b0;
      cfg.cfg_ready   <= 1'b1;
      ctrl_cal_start  <= 1'b0;
      ctrl_weight_c   <= '0;
      ctrl_num_filter <= '0;
      ofm_wr_en       <= 1'b0;
      ofm_wr_addr     <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_cfg         <= 1'b0;
    end else begin
      fin_q     <= all_ones_c;
      ofm_wr_en <= 1'b0;
      done      <= 1'b0;
      err_cfg   <= 1'b0;
      if (state != IDLE && abort) begin
        state          <= IDLE;
        ctrl_cal_start <= 1'b0;
        cfg.cfg_ready  <= 1'b1;
        busy           <= 1'b0;
        pix_cnt        <= '0;
        grp_cnt        <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg.cfg_valid) begin
              num_pixel_q     <= cfg.cfg_num_pixel;
              ctrl_weight_c   <= cfg.cfg_weight_c;
              ctrl_num_filter <= cfg.cfg_num_filter;
              ofm_base_q      <= cfg.cfg_ofm_base;
              pix_cnt         <= '0;
              grp_cnt         <= '0;
              cfg.cfg_ready   <= 1'b0;
              busy            <= 1'b1;
              state           <= CHECK;
            end
          end
          CHECK: begin
            if (illegal_c) begin
              err_cfg       <= 1'b1;
              cfg.cfg_ready <= 1'b1;
              busy          <= 1'b0;
              state         <= IDLE;
            end else begin
              ctrl_cal_start <= 1'b1;
              state          <= RUN;
            end
          end
          RUN: begin
            if (fin_evt_c) begin
              ofm_wr_en   <= 1'b1;
              ofm_wr_addr <= wr_addr_c;
              if (last_grp_c) begin
                grp_cnt <= '0;
                if (last_pix_c) begin
                  ctrl_cal_start <= 1'b0;
                  state          <= DONE;
                end else begin
                  pix_cnt <= pix_cnt + PIX_W'(1);
                end
              end else begin
                grp_cnt <= grp_cnt + CW'(1);
              end
            end
          end
          DONE: begin
            done          <= 1'b1;
            cfg.cfg_ready <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv1x1_layer_scheduler.sv
// Self-checking bench for conv1x1_layer_scheduler: event-indexed reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_conv1x1_layer_scheduler;
  logic        clk;
  logic        reset_n;
  logic        abort;
  logic [3:0]  fin;
  logic        cal_start;
  logic [10:0] wc_out, nf_out;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic        busy, done, err_cfg;

  conv1x1_layer_scheduler_if #(.PIX_W(16)) cfg_bus ();

  conv1x1_layer_scheduler #(.PE_LANES(4), .PIX_W(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg            (cfg_bus),
    .abort          (abort),
    .ctrl_cal_start (cal_start),
    .ctrl_weight_c  (wc_out),
    .ctrl_num_filter(nf_out),
    .ctrl_pe_finish (fin),
    .ofm_wr_en      (wr_en),
    .ofm_wr_addr    (wr_addr),
    .busy           (busy),
    .done           (done),
    .err_cfg        (err_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: phase per layer, writes addressed by flat event index k
  int          m_phase = 0;
  int          m_k = 0;
  int          m_np = 0;
  logic [31:0] m_base = '0;
  logic        m_bad = 1'b0;
  logic        m_fin_prev = 1'b0;
  logic        e_ready = 1'b1, e_busy = 1'b0, e_cal = 1'b0, e_wr = 1'b0;
  logic        e_done = 1'b0, e_err = 1'b0;
  logic [31:0] e_addr = '0;
  logic [10:0] e_wc = '0, e_nf = '0;

  always @(posedge clk or negedge reset_n) begin : model
    int ph, k, ngrp;
    logic ao, evt, wr, dn, er, bad;
    logic [31:0] addr;
    if (!reset_n) begin
      m_phase <= 0; m_k <= 0; m_np <= 0; m_base <= '0; m_bad <= 1'b0;
      m_fin_prev <= 1'b0;
      e_ready <= 1'b1; e_busy <= 1'b0; e_cal <= 1'b0; e_wr <= 1'b0;
      e_done <= 1'b0; e_err <= 1'b0; e_addr <= '0; e_wc <= '0; e_nf <= '0;
    end else begin
      ao = (fin == 4'hF);
      evt = ao && !m_fin_prev;
      ph = m_phase; k = m_k; wr = 1'b0; dn = 1'b0; er = 1'b0; addr = e_addr;
      ngrp = int'(e_nf) / 4;
      case (ph)
        0: if (cfg_bus.cfg_valid) begin
             bad = (cfg_bus.cfg_weight_c == 0) || (cfg_bus.cfg_weight_c % 4 != 0) ||
                   (cfg_bus.cfg_num_filter == 0) || (cfg_bus.cfg_num_filter % 4 != 0) ||
                   (cfg_bus.cfg_num_pixel == 0);
             m_bad  <= bad;
             m_np   <= int'(cfg_bus.cfg_num_pixel);
             m_base <= cfg_bus.cfg_ofm_base;
             e_wc   <= cfg_bus.cfg_weight_c;
             e_nf   <= cfg_bus.cfg_num_filter;
             k = 0;
             ph = 1;
           end
        1: if (abort) ph = 0;
           else if (m_bad) begin er = 1'b1; ph = 0; end
           else ph = 2;
        2: if (abort) ph = 0;
           else if (evt) begin
             wr = 1'b1;
             addr = m_base + 32'((k / ngrp) * int'(e_nf) + (k % ngrp) * 4);
             k++;
             if (k == m_np * ngrp) ph = 3;
           end
        default: begin dn = !abort; ph = 0; end
      endcase
      m_phase <= ph; m_k <= k; m_fin_prev <= ao;
      e_wr <= wr; e_addr <= addr; e_done <= dn; e_err <= er;
      e_ready <= (ph == 0); e_busy <= (ph != 0); e_cal <= (ph == 2);
    end
  end

  // Per-cycle comparison and event logging
  logic [31:0] wr_log[$];
  int done_cnt = 0, err_cnt = 0, cal_rise = 0;
  logic cal_prev = 1'b0;

  always @(negedge clk) begin
    chk("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(e_ready));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("cal_start", 32'(cal_start), 32'(e_cal));
    chk("wr_en", 32'(wr_en), 32'(e_wr));
    chk("done", 32'(done), 32'(e_done));
    chk("err_cfg", 32'(err_cfg), 32'(e_err));
    chk("weight_c", 32'(wc_out), 32'(e_wc));
    chk("num_filter", 32'(nf_out), 32'(e_nf));
    if (e_wr) chk("wr_addr", wr_addr, e_addr);
    if (wr_en) wr_log.push_back(wr_addr);
    if (done) done_cnt++;
    if (err_cfg) err_cnt++;
    if (cal_start && !cal_prev) cal_rise++;
    cal_prev = cal_start;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [15:0] np, input logic [10:0] wc,
                          input logic [10:0] nf, input logic [31:0] base);
    cfg_bus.cfg_num_pixel = np;
    cfg_bus.cfg_weight_c = wc;
    cfg_bus.cfg_num_filter = nf;
    cfg_bus.cfg_ofm_base = base;
    cfg_bus.cfg_valid = 1'b1;
    for (int i = 0; i < 50 && !cfg_bus.cfg_ready; i++) tick(1);
    tick(1);
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic pulse_fin();
    fin = 4'hF; tick(1);
    fin = 4'h0; tick(1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && !cfg_bus.cfg_ready; i++) tick(1);
    chk("idle_timeout", 32'(cfg_bus.cfg_ready), 32'd1);
    tick(2);
  endtask

  int d0, e0, c0;

  initial begin
    reset_n = 1'b0; abort = 1'b0; fin = 4'h0;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_num_pixel = '0; cfg_bus.cfg_weight_c = '0;
    cfg_bus.cfg_num_filter = '0; cfg_bus.cfg_ofm_base = '0;
    tick(3);
    chk("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", wr_addr, 32'd0);
    reset_n = 1'b1;
    tick(2);

    // single legal layer
    wr_log.delete(); d0 = done_cnt;
    send_cfg(16'd2, 11'd8, 11'd8, 32'h100);
    tick(2);
    repeat (4) begin pulse_fin(); tick(1); end
    wait_idle();
    chk("legal_nwr", 32'(wr_log.size()), 32'd4);
    if (wr_log.size() == 4) begin
      chk("legal_a0", wr_log[0], 32'h100);
      chk("legal_a1", wr_log[1], 32'h104);
      chk("legal_a2", wr_log[2], 32'h108);
      chk("legal_a3", wr_log[3], 32'h10C);
    end
    chk("legal_done", 32'(done_cnt - d0), 32'd1);

    // illegal descriptors
    e0 = err_cnt; c0 = cal_rise;
    send_cfg(16'd1, 11'd6, 11'd8, 32'h0);  tick(4);
    send_cfg(16'd1, 11'd8, 11'd0, 32'h0);  tick(4);
    send_cfg(16'd0, 11'd8, 11'd8, 32'h0);  tick(4);
    chk("illegal_err", 32'(err_cnt - e0), 32'd3);
    chk("illegal_cal", 32'(cal_rise - c0), 32'd0);

    // level-held and partial finish patterns
    wr_log.delete(); d0 = done_cnt;
    send_cfg(16'd1, 11'd4, 11'd8, 32'h40);
    tick(2);
    fin = 4'h3; tick(2);
    fin = 4'hF; tick(5);
    fin = 4'h0; tick(1);
    fin = 4'hF; tick(1);
    fin = 4'h0;
    wait_idle();
    chk("level_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) chk("level_a1", wr_log[1], 32'h44);
    chk("level_done", 32'(done_cnt - d0), 32'd1);

    // abort mid-run, descriptor offered while busy is ignored
    wr_log.delete(); d0 = done_cnt;
    send_cfg(16'd1, 11'd4, 11'd16, 32'h300);
    tick(2);
    pulse_fin();
    cfg_bus.cfg_num_filter = 11'd4; cfg_bus.cfg_valid = 1'b1; tick(1);
    cfg_bus.cfg_valid = 1'b0;
    chk("busy_nf_hold", 32'(nf_out), 32'd16);
    abort = 1'b1; tick(1); abort = 1'b0; tick(2);
    chk("abort_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_nwr", 32'(wr_log.size()), 32'd1);
    wr_log.delete();
    send_cfg(16'd1, 11'd4, 11'd4, 32'h200);
    tick(2);
    pulse_fin();
    wait_idle();
    chk("post_abort_a0", (wr_log.size() > 0) ? wr_log[0] : 32'hDEAD_BEEF, 32'h200);
    chk("post_abort_done", 32'(done_cnt - d0), 32'd1);

    // address wrap
    wr_log.delete();
    send_cfg(16'd1, 11'd4, 11'd8, 32'hFFFF_FFFC);
    tick(2);
    pulse_fin(); pulse_fin();
    wait_idle();
    chk("wrap_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk("wrap_a0", wr_log[0], 32'hFFFF_FFFC);
      chk("wrap_a1", wr_log[1], 32'h0000_0000);
    end

    // reset mid-layer
    d0 = done_cnt;
    send_cfg(16'd2, 11'd4, 11'd8, 32'h500);
    tick(2);
    pulse_fin();
    fin = 4'hF;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_cal", 32'(cal_start), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wr", 32'(wr_en), 32'd0);
    chk("arst_nf", 32'(nf_out), 32'd0);
    chk("arst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    fin = 4'h0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    chk("rel_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);

    // randomized layers
    for (int n = 0; n < 40; n++) begin
      logic [10:0] wc, nf;
      logic [15:0] np;
      np = ($urandom % 10 == 0) ? 16'd0 : 16'($urandom_range(1, 3));
      nf = ($urandom % 8 == 0) ? 11'($urandom % 16) : 11'(4 * $urandom_range(1, 3));
      wc = ($urandom % 6 == 0) ? 11'($urandom % 16) : 11'(4 * $urandom_range(1, 4));
      send_cfg(np, wc, nf, $urandom);
      for (int c = 0; c < 200 && !cfg_bus.cfg_ready; c++) begin
        case ($urandom % 10)
          0, 1, 2, 3: fin = 4'hF;
          4, 5, 6:    fin = 4'h0;
          default:    fin = 4'($urandom);
        endcase
        abort = ($urandom % 80 == 0);
        tick(1);
      end
      fin = 4'h0;
      abort = 1'b0;
      if (!cfg_bus.cfg_ready) begin
        abort = 1'b1; tick(1); abort = 1'b0;
      end
      tick(2);
    end

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
